apb4_plic_slave: RTL and testbench
==================================

Name: apb4_plic_slave

Overview:
- APB4 slave front-end for the PLIC register bank. Replaces the fixed zero-wait, never-error bus glue with a parametrised access engine.
- Features: configurable wait states, pipelined read-data latency, address and privilege error checking, and an exactly-once guarantee on register strobes.
- Exactly-once strobes keep claim/complete side effects from being duplicated.
- Sits between the APB4 interconnect and the PLIC dynamic register block.

Parameters:
- PADDR_SIZE, 32: PADDR width.
- PDATA_SIZE, 32: PWDATA/PRDATA width (32 or 64).
- WAIT_STATES, 0: minimum extra access cycles before PREADY (0..15).
- RD_LATENCY, 0: cycles from reg_re to valid reg_rdata (0..15).
- REQUIRE_PRIV, 0: 1 = accesses with PPROT[0]=0 get PSLVERR.

Ports:
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PADDR  in  PADDR_SIZE  address
- PWRITE  in  1  1=write
- PSTRB  in  PDATA_SIZE/8  write byte strobes
- PWDATA  in  PDATA_SIZE  write data
- PPROT  in  3  protection; bit0=privileged
- PRDATA  out  PDATA_SIZE  read data
- PREADY  out  1  transfer complete
- PSLVERR  out  1  transfer error
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_addr  out  PADDR_SIZE  = PADDR, combinational
- reg_be  out  PDATA_SIZE/8  PSTRB on writes, all-ones on reads
- reg_wdata  out  PDATA_SIZE  = PWDATA
- reg_rdata  in  PDATA_SIZE  register bank read data
- reg_err  in  1  combinational decode error for reg_addr (unmapped/read-only on write)

Behaviour:
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, reg_we=0, reg_re=0, state=IDLE, counter=0, captured data=0. Reset mid-transfer aborts it; no strobe follows reset release.
- Per-transfer latency: N = WAIT_STATES for writes; N = max(WAIT_STATES, RD_LATENCY) for reads.
- FSM IDLE: on PSEL & !PENABLE (setup phase), go to ARMED.
- FSM ARMED: this is the first access cycle A0 (PSEL & PENABLE). Evaluate err = misaligned | (REQUIRE_PRIV & !PPROT[0]) | reg_err.
  - Misaligned: PADDR[log2(PDATA_SIZE/8)-1:0] != 0.
  - If !err: assert reg_we (write, PSTRB != 0) or reg_re (read) for this cycle only.
  - Write with PSTRB = 0: completes OKAY, no reg_we.
  - Error: no strobe at all; latch err for PSLVERR.
  - If N = 0: PREADY=1 in A0, then go to IDLE. Else load counter = N and go to WAIT.
- FSM WAIT: decrement counter each cycle. When counter reaches 1, assert PREADY in that cycle (cycle A0+N), then go to IDLE.
- PREADY and PSLVERR are high only in the final access cycle; 0 otherwise.
- Read data:
  - RD_LATENCY = 0: PRDATA = reg_rdata in A0.
  - RD_LATENCY > 0: capture reg_rdata at cycle A0+RD_LATENCY; drive the captured value on PRDATA while PREADY=1.
  - PRDATA = 0 whenever PREADY=0, on writes, and on errored transfers.
- Protocol violations:
  - Access phase in IDLE (no setup seen): PREADY=1, PSLVERR=1 in that cycle, no strobe.
  - PSEL deasserted in ARMED or WAIT: abort to IDLE, clear counter, no PREADY, no further strobes.
- Exactly-once rule: reg_re/reg_we assert at most once per setup phase, whatever the wait states. Back-to-back transfers need a fresh setup phase (IDLE→ARMED).
- Back-to-back with N = 0: one transfer every 2 cycles, no idle cycle needed.
- PADDR/PWRITE/PSTRB/PWDATA are held stable by the master through the access (APB rule); the block does not re-register them.

Test Plan:
- WAIT_STATES=0, RD_LATENCY=0: write 0x0000_0005 to 0x0000_0004 with PSTRB=0xF -> reg_we high exactly 1 cycle in A0 with reg_be=0xF; PREADY=1 in A0; PSLVERR=0.
- RD_LATENCY=2, WAIT_STATES=0: read 0x200004, reg_rdata=0x0000_0003 valid at A0+2 -> reg_re pulses once in A0; PREADY and PRDATA=0x3 at A0+2; PRDATA=0 before that.
- WAIT_STATES=3: read claim address -> single reg_re pulse over 4 access cycles; PREADY at A0+3.
- Errors:
  - Read of PADDR=0x2 -> PSLVERR=1, no reg_re.
  - REQUIRE_PRIV=1, PPROT=3'b000 -> PSLVERR=1.
  - reg_err=1 -> PSLVERR=1, PRDATA=0.
- PSEL dropped in WAIT (WAIT_STATES=4) -> no PREADY; next full transfer completes normally with one strobe.
- PRESETn low during WAIT -> PREADY/PSLVERR/PRDATA=0 immediately; after release, access phase without setup -> PREADY=1, PSLVERR=1.

Source files
------------

// File: rtl/apb4_plic_slave.sv
// APB4 slave front-end for the PLIC register bank: wait states, pipelined read data,
// address/privilege error checking and exactly-once register strobes.
module apb4_plic_slave #(
   parameter int PADDR_SIZE   = 32,
   parameter int PDATA_SIZE   = 32,
   parameter int WAIT_STATES  = 0,
   parameter int RD_LATENCY   = 0,
   parameter int REQUIRE_PRIV = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic [PADDR_SIZE-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [PDATA_SIZE/8-1:0] PSTRB,
   input  logic [PDATA_SIZE-1:0]   PWDATA,
   input  logic [2:0]              PPROT,
   output logic [PDATA_SIZE-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic                    reg_we,
   output logic                    reg_re,
   output logic [PADDR_SIZE-1:0]   reg_addr,
   output logic [PDATA_SIZE/8-1:0] reg_be,
   output logic [PDATA_SIZE-1:0]   reg_wdata,
   input  logic [PDATA_SIZE-1:0]   reg_rdata,
   input  logic                    reg_err,
   output logic [1:0]              dbg_state
);

   localparam int BE_W     = PDATA_SIZE / 8;
   localparam int ADDR_LSB = $clog2(BE_W);
   localparam int N_WR     = WAIT_STATES;
   localparam int N_RD     = (RD_LATENCY > WAIT_STATES) ? RD_LATENCY : WAIT_STATES;
   localparam logic [3:0] N_WR_L    = 4'(N_WR);
   localparam logic [3:0] N_RD_L    = 4'(N_RD);
   // Counter value seen in the cycle A0+RD_LATENCY (counter holds N in A0+1, 1 in A0+N).
   localparam logic [3:0] CAP_CNT_L = 4'(N_RD - RD_LATENCY + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  err_q, wr_q;
   logic [PDATA_SIZE-1:0] data_q;

   logic       access, a0, a0_err, misaligned, priv_err;
   logic       final_wait, protocol_err, done_ok, cap_now;
   logic       cur_err, cur_wr;
   logic [3:0] n_xfer;
   logic       unused_prot;

   // Handshake: PSEL&PENABLE is the request (valid) and PREADY the completion (ready);
   // a transfer retires in the single cycle where both are high, and never before setup.
   assign access       = PSEL & PENABLE;
   assign a0           = (state_q == ST_ARMED) & access;
   assign misaligned   = |PADDR[ADDR_LSB-1:0];
   assign priv_err     = (REQUIRE_PRIV != 0) & ~PPROT[0];
   assign a0_err       = misaligned | priv_err | reg_err;
   assign n_xfer       = PWRITE ? N_WR_L : N_RD_L;
   assign final_wait   = (state_q == ST_WAIT) & PSEL & (cnt_q == 4'd1);
   assign protocol_err = (state_q == ST_IDLE) & access;
   assign done_ok      = (a0 & (n_xfer == 4'd0)) | final_wait;
   assign cur_err      = (state_q == ST_WAIT) ? err_q : a0_err;
   assign cur_wr       = (state_q == ST_WAIT) ? wr_q  : PWRITE;
   assign unused_prot  = ^PPROT[2:1];

   always_comb begin
      cap_now = 1'b0;
      if (RD_LATENCY == 0) cap_now = a0;
      else                 cap_now = (state_q == ST_WAIT) & PSEL & (cnt_q == CAP_CNT_L);
   end

   // Outputs are gated by PRESETn so they drop the instant reset asserts.
   assign PREADY  = PRESETn & (done_ok | protocol_err);
   assign PSLVERR = PRESETn & (protocol_err | (done_ok & cur_err));
   assign PRDATA  = (PRESETn & done_ok & ~cur_err & ~cur_wr) ?
                    (cap_now ? reg_rdata : data_q) : '0;

   assign reg_we    = a0 & ~a0_err & PWRITE & (|PSTRB);
   assign reg_re    = a0 & ~a0_err & ~PWRITE;
   assign reg_addr  = PADDR;
   assign reg_be    = PWRITE ? PSTRB : '1;
   assign reg_wdata = PWDATA;
   assign dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (PSEL & ~PENABLE) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!PSEL) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (PENABLE) begin
               if (n_xfer == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = n_xfer;
               end
            end
         end
         ST_WAIT: begin
            if (!PSEL || cnt_q == 4'd1) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (a0) begin
            err_q <= a0_err;
            wr_q  <= PWRITE;
         end
         if (cap_now) data_q <= reg_rdata;
      end
   end

endmodule

// File: tb/tb_apb4_plic_slave.sv
// Bench for apb4_plic_slave: four parameter sets share one APB bus, each with its own PSEL.
module tb_apb4_plic_slave;

   localparam int EXP_W = 49;

   logic        clk, rst_n;
   logic [3:0]  psel;
   logic        penable, pwrite, reg_err;
   logic [31:0] paddr, pwdata, reg_rdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;

   logic [31:0] prdata    [4];
   logic        pready    [4];
   logic        pslverr   [4];
   logic        reg_we    [4];
   logic        reg_re    [4];
   logic [31:0] reg_addr  [4];
   logic [3:0]  reg_be    [4];
   logic [31:0] reg_wdata [4];
   logic [1:0]  dbg_state [4];

   int checks = 0;
   int errors = 0;

   logic [EXP_W-1:0] exp_q[$];

   typedef struct {
      int          dut;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [2:0]  prot;
      logic [31:0] rdata;
      logic        rerr;
      int          lat;
      logic        err;
      logic [31:0] prdata;
      int          we;
      int          re;
      logic [3:0]  be;
   } vec_t;

   vec_t vecs[16];

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   apb4_plic_slave #(.WAIT_STATES(0), .RD_LATENCY(0), .REQUIRE_PRIV(0)) u0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PPROT(pprot), .PRDATA(prdata[0]),
      .PREADY(pready[0]), .PSLVERR(pslverr[0]), .reg_we(reg_we[0]), .reg_re(reg_re[0]),
      .reg_addr(reg_addr[0]), .reg_be(reg_be[0]), .reg_wdata(reg_wdata[0]),
      .reg_rdata(reg_rdata), .reg_err(reg_err), .dbg_state(dbg_state[0]));

   apb4_plic_slave #(.WAIT_STATES(0), .RD_LATENCY(2), .REQUIRE_PRIV(1)) u1 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PPROT(pprot), .PRDATA(prdata[1]),
      .PREADY(pready[1]), .PSLVERR(pslverr[1]), .reg_we(reg_we[1]), .reg_re(reg_re[1]),
      .reg_addr(reg_addr[1]), .reg_be(reg_be[1]), .reg_wdata(reg_wdata[1]),
      .reg_rdata(reg_rdata), .reg_err(reg_err), .dbg_state(dbg_state[1]));

   apb4_plic_slave #(.WAIT_STATES(3), .RD_LATENCY(0), .REQUIRE_PRIV(0)) u2 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PPROT(pprot), .PRDATA(prdata[2]),
      .PREADY(pready[2]), .PSLVERR(pslverr[2]), .reg_we(reg_we[2]), .reg_re(reg_re[2]),
      .reg_addr(reg_addr[2]), .reg_be(reg_be[2]), .reg_wdata(reg_wdata[2]),
      .reg_rdata(reg_rdata), .reg_err(reg_err), .dbg_state(dbg_state[2]));

   apb4_plic_slave #(.WAIT_STATES(4), .RD_LATENCY(2), .REQUIRE_PRIV(0)) u3 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[3]), .PENABLE(penable), .PADDR(paddr),
      .PWRITE(pwrite), .PSTRB(pstrb), .PWDATA(pwdata), .PPROT(pprot), .PRDATA(prdata[3]),
      .PREADY(pready[3]), .PSLVERR(pslverr[3]), .reg_we(reg_we[3]), .reg_re(reg_re[3]),
      .reg_addr(reg_addr[3]), .reg_be(reg_be[3]), .reg_wdata(reg_wdata[3]),
      .reg_rdata(reg_rdata), .reg_err(reg_err), .dbg_state(dbg_state[3]));

   function automatic int rl_of(input int d);
      return (d == 1 || d == 3) ? 2 : 0;
   endfunction

   // A value guaranteed to differ from v, so stale or early captures show up.
   function automatic logic [31:0] garbage(input logic [31:0] v);
      return v ^ (32'h1 << $urandom_range(31, 0));
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver + monitor for one full setup/access transfer
   task automatic run_xfer(input vec_t v, input int idx);
      int               d, cyc, we_n, re_n;
      logic [3:0]       be_seen;
      logic             got_ready, leak, act_err;
      logic [31:0]      act_rd;
      logic [EXP_W-1:0] e;
      d = v.dut; cyc = 0; we_n = 0; re_n = 0; be_seen = '0;
      got_ready = 1'b0; leak = 1'b0; act_err = 1'b0; act_rd = '0;
      exp_q.push_back({8'(v.lat), v.err, 2'(v.we), 2'(v.re), v.be, v.prdata});
      @(posedge clk); #1;
      psel = '0; psel[d] = 1'b1; penable = 1'b0;
      paddr = v.addr; pwrite = v.wr; pstrb = v.strb; pwdata = v.wdata;
      pprot = v.prot; reg_err = v.rerr; reg_rdata = garbage(v.rdata);
      @(posedge clk); #1;
      penable = 1'b1;
      reg_rdata = (rl_of(d) == 0) ? v.rdata : garbage(v.rdata);
      while (!got_ready && cyc < 40) begin
         @(negedge clk);
         if (reg_we[d]) begin
            we_n++; be_seen = reg_be[d];
            check($sformatf("v%0d reg_wdata", idx), reg_wdata[d], v.wdata);
         end
         if (reg_re[d]) begin
            re_n++; be_seen = reg_be[d];
            check($sformatf("v%0d reg_addr", idx), reg_addr[d], v.addr);
         end
         if (pready[d]) begin
            got_ready = 1'b1; act_err = pslverr[d]; act_rd = prdata[d];
         end else begin
            if (prdata[d] != 0 || pslverr[d]) leak = 1'b1;
            @(posedge clk); #1;
            cyc++;
            reg_rdata = (cyc == rl_of(d)) ? v.rdata : garbage(v.rdata);
         end
      end
      check($sformatf("v%0d pready seen", idx), got_ready, 1'b1);
      @(posedge clk); #1;
      psel = '0; penable = 1'b0;
      @(negedge clk);
      if (reg_we[d] || reg_re[d] || pready[d]) leak = 1'b1;
      e = exp_q.pop_front();
      check($sformatf("v%0d latency", idx), cyc, e[48:41]);
      check($sformatf("v%0d pslverr", idx), act_err, e[40]);
      check($sformatf("v%0d we count", idx), we_n, e[39:38]);
      check($sformatf("v%0d re count", idx), re_n, e[37:36]);
      check($sformatf("v%0d reg_be", idx), be_seen, e[35:32]);
      check($sformatf("v%0d prdata", idx), act_rd, e[31:0]);
      check($sformatf("v%0d quiet outside final cycle", idx), leak, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_re, n_ready;
      //          dut wr  addr          strb  wdata          prot    rdata          rerr lat err prdata        we re be
      vecs[0]  = '{0, 1'b1, 32'h0000_0004, 4'hF, 32'h0000_0005, 3'b001, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1, 0, 4'hF};
      vecs[1]  = '{0, 1'b0, 32'h0000_0008, 4'hF, 32'h0,         3'b001, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 32'hDEAD_BEEF, 0, 1, 4'hF};
      vecs[2]  = '{0, 1'b0, 32'h0000_0002, 4'hF, 32'h0,         3'b001, 32'h1234,      1'b0, 0, 1'b1, 32'h0,         0, 0, 4'h0};
      vecs[3]  = '{0, 1'b1, 32'h0000_0010, 4'h0, 32'hFFFF,      3'b001, 32'h0,         1'b0, 0, 1'b0, 32'h0,         0, 0, 4'h0};
      vecs[4]  = '{0, 1'b0, 32'h0000_000C, 4'hF, 32'h0,         3'b001, 32'h55,        1'b1, 0, 1'b1, 32'h0,         0, 0, 4'h0};
      vecs[5]  = '{0, 1'b1, 32'h0000_000C, 4'h3, 32'hABCD_1234, 3'b000, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1, 0, 4'h3};
      vecs[6]  = '{0, 1'b0, 32'h0000_0020, 4'hF, 32'h0,         3'b000, 32'h600D,      1'b0, 0, 1'b0, 32'h600D,      0, 1, 4'hF};
      vecs[7]  = '{1, 1'b0, 32'h0020_0004, 4'hF, 32'h0,         3'b001, 32'h3,         1'b0, 2, 1'b0, 32'h3,         0, 1, 4'hF};
      vecs[8]  = '{1, 1'b0, 32'h0020_0004, 4'hF, 32'h0,         3'b000, 32'h3,         1'b0, 2, 1'b1, 32'h0,         0, 0, 4'h0};
      vecs[9]  = '{1, 1'b1, 32'h0020_0000, 4'hF, 32'h9,         3'b001, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1, 0, 4'hF};
      vecs[10] = '{1, 1'b1, 32'h0020_0000, 4'hF, 32'h9,         3'b000, 32'h0,         1'b0, 0, 1'b1, 32'h0,         0, 0, 4'h0};
      vecs[11] = '{2, 1'b0, 32'h0020_0004, 4'hF, 32'h0,         3'b001, 32'h7,         1'b0, 3, 1'b0, 32'h7,         0, 1, 4'hF};
      vecs[12] = '{2, 1'b1, 32'h0020_0004, 4'hF, 32'h1,         3'b001, 32'h0,         1'b0, 3, 1'b0, 32'h0,         1, 0, 4'hF};
      vecs[13] = '{2, 1'b1, 32'h0020_0201, 4'hF, 32'h1,         3'b001, 32'h0,         1'b0, 3, 1'b1, 32'h0,         0, 0, 4'h0};
      vecs[14] = '{3, 1'b0, 32'h0020_0004, 4'hF, 32'h0,         3'b001, 32'h0000_00A5, 1'b0, 4, 1'b0, 32'hA5,        0, 1, 4'hF};
      vecs[15] = '{3, 1'b1, 32'h0000_0000, 4'hF, 32'h1,         3'b001, 32'h0,         1'b1, 4, 1'b1, 32'h0,         0, 0, 4'h0};

      rst_n = 1'b0; psel = '0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
      pstrb = '0; pwdata = '0; pprot = 3'b001; reg_rdata = '0; reg_err = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("reset pready d%0d", d), pready[d], 1'b0);
         check($sformatf("reset pslverr d%0d", d), pslverr[d], 1'b0);
         check($sformatf("reset prdata d%0d", d), prdata[d], 32'h0);
         check($sformatf("reset strobes d%0d", d), {reg_we[d], reg_re[d]}, 2'b00);
      end
      @(posedge clk); #1 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) run_xfer(vecs[i], i);

      // back-to-back N=0 reads: setup, access, setup, access
      n_re = 0; n_ready = 0;
      @(posedge clk); #1;
      psel = 4'b0001; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pprot = 3'b001;
      reg_err = 1'b0; reg_rdata = 32'h11;
      @(negedge clk); n_re += int'(reg_re[0]); n_ready += int'(pready[0]);
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk); n_re += int'(reg_re[0]);
      check("b2b first pready", pready[0], 1'b1);
      check("b2b first prdata", prdata[0], 32'h11);
      @(posedge clk); #1 penable = 1'b0; paddr = 32'h14; reg_rdata = 32'h22;
      @(negedge clk); n_re += int'(reg_re[0]); n_ready += int'(pready[0]);
      @(posedge clk); #1 penable = 1'b1;
      @(negedge clk); n_re += int'(reg_re[0]);
      check("b2b second pready", pready[0], 1'b1);
      check("b2b second prdata", prdata[0], 32'h22);
      check("b2b re count", n_re, 2);
      check("b2b pready in setup", n_ready, 0);
      @(posedge clk); #1 psel = '0; penable = 1'b0;

      // PSEL dropped in WAIT on the 4-wait-state instance
      n_re = 0; n_ready = 0;
      @(posedge clk); #1;
      psel = 4'b1000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0020_0004; reg_rdata = 32'h5;
      @(posedge clk); #1 penable = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); n_re += int'(reg_re[3]); n_ready += int'(pready[3]);
         @(posedge clk); #1;
      end
      psel = '0; penable = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); n_re += int'(reg_re[3]); n_ready += int'(pready[3]);
      end
      check("abort re count", n_re, 1);
      check("abort no pready", n_ready, 0);
      check("abort state idle", dbg_state[3], 2'd0);
      run_xfer(vecs[14], 100);

      // reset asserted during WAIT, then access phase without setup
      @(posedge clk); #1;
      psel = 4'b1000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0020_0004; reg_rdata = 32'h77;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("reset mid-wait pready", pready[3], 1'b0);
      check("reset mid-wait pslverr", pslverr[3], 1'b0);
      check("reset mid-wait prdata", prdata[3], 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("no-setup pready", pready[3], 1'b1);
      check("no-setup pslverr", pslverr[3], 1'b1);
      check("no-setup strobes", {reg_we[3], reg_re[3]}, 2'b00);
      check("no-setup prdata", prdata[3], 32'h0);
      @(posedge clk); #1 psel = '0; penable = 1'b0;
      @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
